mem_port_master: RTL

- Initiator for the split-port block-RAM protocol served by the on-chip memory adapter (re / we[3:0] / addr / din / dout / dready).
- Converts single-beat commands from a debug or loader client into one memory transaction each.
- Holds request signals stable until dready, returns read data, and aborts on timeout.
- Lets test logic preload or inspect data memory without the processor core.

---
 rtl/mem_port_pkg.sv | 16 +
 rtl/mem_port_master_sat_counter.sv | 21 ++
 rtl/mem_port_master.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port master.
//   state_t  : FSM encoding (IDLE / REQ / RESP)
//   BE_NONE  : all byte lanes disabled (illegal for a write)
//   BE_WORD  : all byte lanes enabled
package mem_port_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_port_master_sat_counter.sv
// Saturating up-counter used for the transaction statistics.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count enable; ignored once q is all-ones
//   q        : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/mem_port_master.sv
// Single-beat command initiator for the split-port block-RAM adapter.
// Each accepted command becomes one read or write transaction whose strobes
// are held until mem_dready or until TIMEOUT cycles pass, followed by a
// one-cycle response pulse with strobes low.
//   cmd_*            : client command (valid/ready handshake)
//   rsp_valid/err    : one-cycle completion pulse, err = timeout or be==0 write
//   rsp_rdata        : last successfully read word
//   mem_*            : adapter port (re, we[3:0], addr, dout, din, dready)
//   rd/wr/err_cnt    : saturating statistics
module mem_port_master
   import mem_port_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int TIMEOUT = 200,
   parameter int TO_W    = 8,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [3:0]        cmd_be,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              mem_re,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_dout,
   input  logic [31:0]       mem_din,
   input  logic              mem_dready,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   // Counter value seen in the last REQ cycle allowed without dready.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state, nextState;
   logic [TO_W-1:0] toCnt;
   logic            curWrite;
   logic            illegalCmd;
   logic            timeoutHit;

   assign cmd_ready  = (state == IDLE) && !rst;
   assign illegalCmd = cmd_write && (cmd_be == BE_NONE);
   assign timeoutHit = (toCnt == TO_LAST);

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (cmd_valid) nextState = illegalCmd ? RESP : REQ;
         REQ:     if (mem_dready || timeoutHit) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         toCnt     <= '0;
         curWrite  <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= BE_NONE;
         mem_addr  <= '0;
         mem_dout  <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= nextState;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               toCnt <= '0;
               if (cmd_valid) begin
                  curWrite <= cmd_write;
                  if (illegalCmd) begin
                     // No bus activity: report the error straight away.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     mem_re   <= !cmd_write;
                     mem_we   <= cmd_write ? cmd_be : BE_NONE;
                     mem_addr <= cmd_addr;
                     mem_dout <= cmd_wdata;
                  end
               end
            end
            REQ: begin
               // dready takes priority over a timeout on the same edge.
               if (mem_dready) begin
                  mem_re    <= 1'b0;
                  mem_we    <= BE_NONE;
                  rsp_valid <= 1'b1;
                  if (!curWrite) rsp_rdata <= mem_din;
               end else if (timeoutHit) begin
                  mem_re    <= 1'b0;
                  mem_we    <= BE_NONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // rsp_valid/rsp_err are high exactly during RESP, so they qualify the
   // statistics update for the transaction just finished.
   logic rdInc, wrInc, errInc;
   assign rdInc  = (state == RESP) && !rsp_err && !curWrite;
   assign wrInc  = (state == RESP) && !rsp_err &&  curWrite;
   assign errInc = (state == RESP) &&  rsp_err;

   sat_counter #(.W(CNT_W)) uRdCnt  (.clk(clk), .rst(rst), .inc(rdInc),  .q(rd_cnt));
   sat_counter #(.W(CNT_W)) uWrCnt  (.clk(clk), .rst(rst), .inc(wrInc),  .q(wr_cnt));
   sat_counter #(.W(CNT_W)) uErrCnt (.clk(clk), .rst(rst), .inc(errInc), .q(err_cnt));

endmodule
